// File: rtl/sobel_pkg.sv
// Constants shared by the sobel frame controller and the sobel engine:
// image geometry, word counts and the one-hot controller state encoding.
package sobel_pkg;

   localparam int image_size  = 128;
   localparam int kernel_size = 3;
   localparam int IN_WORDS    = image_size * image_size;
   localparam int OUT_SIDE    = image_size - kernel_size + 1;
   localparam int OUT_WORDS   = OUT_SIDE * OUT_SIDE;

   typedef logic [4:0] state_t;

   localparam logic [4:0] ST_IDLE       = 5'b00001;
   localparam logic [4:0] ST_LOAD       = 5'b00010;
   localparam logic [4:0] ST_RUN        = 5'b00100;
   localparam logic [4:0] ST_DRAIN_RD   = 5'b01000;
   localparam logic [4:0] ST_DRAIN_WAIT = 5'b10000;

endpackage

// File: rtl/sobel_drain_reader.sv
// Result drain: issues one GX/GY read per word, presents {GX,GY} on the
// output stream and holds it until accepted; flags the final word with m_last.
module sobel_drain_reader
   import sobel_pkg::*;
#(
   parameter int width                  = 8,
   parameter int G_depth_bits           = 14,
   parameter int NUMBER_OF_OUTPUT_WORDS = OUT_WORDS
) (
   input  logic                    clk_i,
   input  logic                    reset_i,
   input  logic                    clr_i,
   input  logic                    rd_phase_i,
   input  logic                    wait_phase_i,
   input  logic [width-1:0]        gx_data_i,
   input  logic [width-1:0]        gy_data_i,
   input  logic                    m_ready_i,
   output logic                    rd_en_o,
   output logic [G_depth_bits-1:0] rd_addr_o,
   output logic                    m_valid_o,
   output logic [2*width-1:0]      m_data_o,
   output logic                    m_last_o
);

   localparam logic [G_depth_bits-1:0] G_LAST = G_depth_bits'(NUMBER_OF_OUTPUT_WORDS - 1);

   logic [G_depth_bits-1:0] cnt_q, cnt_d;
   logic                    valid_q, valid_d;
   logic                    last_q, last_d;
   logic                    first_q, first_d;
   logic [2*width-1:0]      hold_q, hold_d;
   logic                    take;

   assign take = wait_phase_i & valid_q & m_ready_i;

   always_comb begin
      cnt_d   = cnt_q;
      valid_d = valid_q;
      last_d  = last_q;
      hold_d  = hold_q;
      first_d = rd_phase_i;
      if (clr_i)
         cnt_d = '0;
      else if (take && !last_q)
         cnt_d = cnt_q + G_depth_bits'(1);
      if (rd_phase_i) begin
         valid_d = 1'b1;
         last_d  = (cnt_q == G_LAST);
      end else if (take) begin
         valid_d = 1'b0;
         last_d  = 1'b0;
      end
      if (first_q)
         hold_d = {gx_data_i, gy_data_i};
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         cnt_q   <= '0;
         valid_q <= 1'b0;
         last_q  <= 1'b0;
         first_q <= 1'b0;
         hold_q  <= '0;
      end else begin
         cnt_q   <= cnt_d;
         valid_q <= valid_d;
         last_q  <= last_d;
         first_q <= first_d;
         hold_q  <= hold_d;
      end
   end

   // RAM data arrives during the first wait cycle; pass it straight through
   // then so a word can be offered every second cycle, and hold it afterwards.
   assign m_data_o  = first_q ? {gx_data_i, gy_data_i} : hold_q;
   assign rd_en_o   = rd_phase_i;
   assign rd_addr_o = cnt_q;
   assign m_valid_o = valid_q;
   assign m_last_o  = last_q;

endmodule

// File: rtl/sobel_frame_ctrl.sv
// Frame sequencer: loads a pixel frame into A_RAM, runs the sobel engine, then streams {GX,GY}.
// Build option: FRAME_LAST_CHECK_EN enables the sticky s_last framing error on err.
module sobel_frame_ctrl
   import sobel_pkg::*;
#(
   parameter int width                  = 8,
   parameter int A_depth_bits           = 14,
   parameter int G_depth_bits           = 14,
   parameter int NUMBER_OF_INPUT_WORDS  = IN_WORDS,
   parameter int NUMBER_OF_OUTPUT_WORDS = OUT_WORDS
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    s_valid,
   input  logic [width-1:0]        s_data,
   input  logic                    s_last,
   output logic                    s_ready,
   output logic                    A_write_en,
   output logic [A_depth_bits-1:0] A_write_address,
   output logic [width-1:0]        A_write_data_in,
   output logic                    sobel_start,
   input  logic                    sobel_done,
   output logic                    GX_read_en,
   output logic                    GY_read_en,
   output logic [G_depth_bits-1:0] GX_read_address,
   output logic [G_depth_bits-1:0] GY_read_address,
   input  logic [width-1:0]        GX_read_data_out,
   input  logic [width-1:0]        GY_read_data_out,
   output logic                    m_valid,
   output logic [2*width-1:0]      m_data,
   output logic                    m_last,
   input  logic                    m_ready,
   output logic                    busy,
   output logic                    err
);

   localparam logic [A_depth_bits-1:0] A_LAST = A_depth_bits'(NUMBER_OF_INPUT_WORDS - 1);

   state_t                  state_q, state_d;
   logic [A_depth_bits-1:0] addr_q, addr_d;
   logic                    start_q, start_d;
   logic                    accept;
   logic                    last_beat;
   logic                    drain_clr;
   logic                    rd_en;
   logic [G_depth_bits-1:0] rd_addr;

   assign s_ready         = (state_q == ST_IDLE) | (state_q == ST_LOAD);
   assign accept          = s_valid & s_ready;
   assign last_beat       = accept & (addr_q == A_LAST);
   assign A_write_en      = accept;
   assign A_write_address = addr_q;
   assign A_write_data_in = s_data;
   assign sobel_start     = start_q;
   assign busy            = (state_q != ST_IDLE);
   assign drain_clr       = (state_q == ST_RUN) & sobel_done;

   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      start_d = start_q;
      case (state_q)
         ST_IDLE, ST_LOAD: begin
            if (last_beat) begin
               addr_d  = '0;
               start_d = 1'b1;
               state_d = ST_RUN;
            end else if (accept) begin
               addr_d  = addr_q + A_depth_bits'(1);
               state_d = ST_LOAD;
            end
         end
         ST_RUN: begin
            if (sobel_done) begin
               start_d = 1'b0;
               state_d = ST_DRAIN_RD;
            end
         end
         ST_DRAIN_RD: state_d = ST_DRAIN_WAIT;
         ST_DRAIN_WAIT: begin
            if (m_valid && m_ready)
               state_d = m_last ? ST_IDLE : ST_DRAIN_RD;
         end
         default: begin
            state_d = ST_IDLE;
            addr_d  = '0;
            start_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_IDLE;
         addr_q  <= '0;
         start_q <= 1'b0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         start_q <= start_d;
      end
   end

`ifdef FRAME_LAST_CHECK_EN
   logic err_q;

   // s_last must mark exactly the final pixel of the frame; any disagreement sticks until reset.
   always_ff @(posedge clk) begin
      if (reset)
         err_q <= 1'b0;
      else if (accept && (s_last != (addr_q == A_LAST)))
         err_q <= 1'b1;
   end

   assign err = err_q;
`else
   logic unused_s_last;

   assign unused_s_last = s_last;
   assign err           = 1'b0;
`endif

   sobel_drain_reader #(
      .width                  (width),
      .G_depth_bits           (G_depth_bits),
      .NUMBER_OF_OUTPUT_WORDS (NUMBER_OF_OUTPUT_WORDS)
   ) u_drain (
      .clk_i        (clk),
      .reset_i      (reset),
      .clr_i        (drain_clr),
      .rd_phase_i   (state_q == ST_DRAIN_RD),
      .wait_phase_i (state_q == ST_DRAIN_WAIT),
      .gx_data_i    (GX_read_data_out),
      .gy_data_i    (GY_read_data_out),
      .m_ready_i    (m_ready),
      .rd_en_o      (rd_en),
      .rd_addr_o    (rd_addr),
      .m_valid_o    (m_valid),
      .m_data_o     (m_data),
      .m_last_o     (m_last)
   );

   assign GX_read_en      = rd_en;
   assign GY_read_en      = rd_en;
   assign GX_read_address = rd_addr;
   assign GY_read_address = rd_addr;

endmodule

// File: tb/tb_sobel_frame_ctrl.sv
// Self-checking bench for sobel_frame_ctrl: randomized pixel/ready stimulus,
// stub engine, result RAM model and a cycle-level expectation model.
module tb_sobel_frame_ctrl;

   localparam int NIN  = 1024;
   localparam int NOUT = 900;

   logic        clk = 1'b0;
   logic        reset;
   logic        s_valid;
   logic [7:0]  s_data;
   logic        s_last;
   logic        s_ready;
   logic        A_write_en;
   logic [13:0] A_write_address;
   logic [7:0]  A_write_data_in;
   logic        sobel_start;
   logic        sobel_done;
   logic        GX_read_en, GY_read_en;
   logic [13:0] GX_read_address, GY_read_address;
   logic [7:0]  GX_read_data_out, GY_read_data_out;
   logic        m_valid;
   logic [15:0] m_data;
   logic        m_last;
   logic        m_ready;
   logic        busy;
   logic        err;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   sobel_frame_ctrl #(
      .width                  (8),
      .A_depth_bits           (14),
      .G_depth_bits           (14),
      .NUMBER_OF_INPUT_WORDS  (NIN),
      .NUMBER_OF_OUTPUT_WORDS (NOUT)
   ) dut (
      .clk              (clk),
      .reset            (reset),
      .s_valid          (s_valid),
      .s_data           (s_data),
      .s_last           (s_last),
      .s_ready          (s_ready),
      .A_write_en       (A_write_en),
      .A_write_address  (A_write_address),
      .A_write_data_in  (A_write_data_in),
      .sobel_start      (sobel_start),
      .sobel_done       (sobel_done),
      .GX_read_en       (GX_read_en),
      .GY_read_en       (GY_read_en),
      .GX_read_address  (GX_read_address),
      .GY_read_address  (GY_read_address),
      .GX_read_data_out (GX_read_data_out),
      .GY_read_data_out (GY_read_data_out),
      .m_valid          (m_valid),
      .m_data           (m_data),
      .m_last           (m_last),
      .m_ready          (m_ready),
      .busy             (busy),
      .err              (err)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Stub engine: sobel_done pulses 50 cycles after sobel_start is seen high.
   int eng_cnt = 0;
   bit spurious = 1'b0;
   initial begin
      sobel_done = 1'b0;
      forever begin
         @(posedge clk); #2;
         if (sobel_start && !reset) eng_cnt++;
         else eng_cnt = 0;
         sobel_done = (eng_cnt == 50) | spurious;
      end
   end

   // Result RAM model, 1-cycle read latency: GX=addr[7:0], GY=~addr[7:0].
   bit          rd_px, rd_py;
   logic [13:0] rd_ax, rd_ay;
   always @(negedge clk) begin
      rd_px = GX_read_en;  rd_ax = GX_read_address;
      rd_py = GY_read_en;  rd_ay = GY_read_address;
   end
   initial begin
      GX_read_data_out = 8'h00;
      GY_read_data_out = 8'h00;
      forever begin
         @(posedge clk); #1;
         if (rd_px) GX_read_data_out = rd_ax[7:0];
         if (rd_py) GY_read_data_out = ~rd_ay[7:0];
      end
   end

   bit rand_ready = 1'b0;
   initial begin
      m_ready = 1'b1;
      forever begin
         @(posedge clk); #1;
         m_ready = rand_ready ? ($urandom_range(0, 1) == 1) : 1'b1;
      end
   end

   // Expectation model, evaluated on the settled view of each cycle.
   bit          m_load, m_run, m_rd, m_out, m_err, m_stall;
   int          m_wr, m_k;
   logic [15:0] m_held;
   logic [15:0] out_log[$];

   always @(negedge clk) begin
      if (reset) begin
         m_load = 1; m_run = 0; m_rd = 0; m_out = 0; m_err = 0; m_stall = 0;
         m_wr = 0; m_k = 0;
      end else begin
         chk("s_ready", s_ready, m_load);
         chk("A_write_en", A_write_en, s_valid & m_load);
         if (A_write_en) begin
            chk("A_write_address", A_write_address, m_wr);
            chk("A_write_data", A_write_data_in, m_wr % 256);
         end
         chk("sobel_start", sobel_start, m_run);
         chk("GX_read_en", GX_read_en, m_rd);
         chk("GY_read_en", GY_read_en, m_rd);
         if (m_rd) begin
            chk("GX_read_address", GX_read_address, m_k);
            chk("GY_read_address", GY_read_address, m_k);
         end
         chk("m_valid", m_valid, m_out);
         chk("m_last", m_last, m_out && (m_k == NOUT - 1));
         if (m_out) begin
            chk("m_data", m_data, {m_k[7:0], ~m_k[7:0]});
            if (m_stall) chk("m_data_hold", m_data, m_held);
            if (m_ready) out_log.push_back(m_data);
         end
         chk("busy", busy, !(m_load && m_wr == 0));
         chk("err", err, m_err);
`ifdef FRAME_LAST_CHECK_EN
         if (s_valid && m_load && (s_last != (m_wr == NIN - 1))) m_err = 1;
`endif
         m_stall = m_out && !m_ready;
         m_held  = m_data;
         if (m_load) begin
            if (s_valid) begin
               m_wr++;
               if (m_wr == NIN) begin m_wr = 0; m_load = 0; m_run = 1; end
            end
         end else if (m_run) begin
            if (sobel_done) begin m_run = 0; m_rd = 1; m_k = 0; end
         end else if (m_rd) begin
            m_rd = 0; m_out = 1;
         end else if (m_out && m_ready) begin
            m_out = 0;
            if (m_k == NOUT - 1) m_load = 1;
            else begin m_k++; m_rd = 1; end
         end
      end
   end

   task automatic load_frame(input bit gaps, input int bad_last, input int spur_at);
      int  i = 0;
      bit  v;
      @(posedge clk); #1;
      while (i < NIN) begin
         v        = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
         s_valid  = v;
         s_data   = v ? i[7:0] : 8'($urandom);
         spurious = (i == spur_at);
`ifdef FRAME_LAST_CHECK_EN
         s_last   = (i == NIN - 1) ^ (i == bad_last);
`else
         s_last   = ($urandom_range(0, 1) == 1) ^ (bad_last < 0);
`endif
         @(posedge clk); #1;
         if (v) i++;
      end
      s_valid  = 1'b0;
      s_last   = 1'b0;
      spurious = 1'b0;
   endtask

   task automatic wait_idle(input int budget);
      int c = 0;
      @(negedge clk);
      while (busy && c < budget) begin
         @(negedge clk);
         c++;
      end
      chk("idle_timeout", busy, 0);
   endtask

   task automatic frame_checks();
      chk("words", out_log.size(), NOUT);
      if (out_log.size() == NOUT) begin
         chk("word0", out_log[0], 16'h00FF);
         chk("word1", out_log[1], 16'h01FE);
         chk("word_last", out_log[NOUT-1], 16'h837C);
      end
   endtask

   initial begin
      reset = 1'b1; s_valid = 1'b0; s_data = 8'h00; s_last = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_s_ready", s_ready, 1);
      chk("rst_A_write_en", A_write_en, 0);
      chk("rst_A_write_address", A_write_address, 0);
      chk("rst_sobel_start", sobel_start, 0);
      chk("rst_GX_read_en", GX_read_en, 0);
      chk("rst_GX_read_address", GX_read_address, 0);
      chk("rst_m_valid", m_valid, 0);
      chk("rst_m_last", m_last, 0);
      chk("rst_m_data", m_data, 0);
      chk("rst_busy", busy, 0);
      chk("rst_err", err, 0);
      reset = 1'b0;

      out_log.delete();
      load_frame(1'b0, -1, -1);
      wait_idle(20000);
      frame_checks();

      rand_ready = 1'b1;
      out_log.delete();
      load_frame(1'b1, 100, 10);
      wait_idle(40000);
      frame_checks();
`ifdef FRAME_LAST_CHECK_EN
      chk("err_sticky", err, 1);
`else
      chk("err_tied", err, 0);
`endif

      load_frame(1'b1, -1, -1);
      repeat (20) @(posedge clk);
      #1;
      chk("run_start_before_reset", sobel_start, 1);
      reset = 1'b1;
      @(posedge clk); #1;
      chk("abort_sobel_start", sobel_start, 0);
      chk("abort_s_ready", s_ready, 1);
      chk("abort_busy", busy, 0);
      chk("abort_err", err, 0);
      reset = 1'b0;

      out_log.delete();
      load_frame(1'b1, -1, 500);
      wait_idle(40000);
      frame_checks();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/sobel_frame_ctrl.md
SOBEL_FRAME_CTRL -- requirements
Module: sobel_frame_ctrl

Interface
REQ-001 Parameters (name, default, meaning): width, 8, pixel bits; A_depth_bits, 14, A_RAM address bits; G_depth_bits, 14, GX/GY_RAM address bits; NUMBER_OF_INPUT_WORDS, 16384, pixels per frame; NUMBER_OF_OUTPUT_WORDS, 15876, results per frame.
REQ-002 clk  in  1  sole clock, all logic on rising edge.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 s_valid  in  1 / s_data  in  width / s_last  in  1 / s_ready  out  1: input pixel stream.
REQ-005 A_write_en  out  1 / A_write_address  out  A_depth_bits / A_write_data_in  out  width: A_RAM write port.
REQ-006 sobel_start  out  1 / sobel_done  in  1: sobel engine control; engine is held cleared while start is low.
REQ-007 GX_read_en, GY_read_en  out  1 / GX_read_address, GY_read_address  out  G_depth_bits / GX_read_data_out, GY_read_data_out  in  width: result RAM read ports, 1-cycle synchronous read latency.
REQ-008 m_valid  out  1 / m_data  out  2*width ({GX,GY}) / m_last  out  1 / m_ready  in  1: result stream.
REQ-009 busy  out  1 (state != IDLE); err  out  1 (sticky framing error).

Function
REQ-010 States: IDLE, LOAD, RUN, DRAIN_RD, DRAIN_WAIT; one-hot encoding.
REQ-011 IDLE: s_ready=1; first accepted beat (s_valid&s_ready) writes address 0 and enters LOAD.
REQ-012 LOAD: s_ready=1; each accepted beat writes A_RAM in the same cycle (combinational write_en = s_valid&s_ready), address increments 0..NUMBER_OF_INPUT_WORDS-1.
REQ-013 Beat at address NUMBER_OF_INPUT_WORDS-1 ends LOAD -> RUN; s_ready=0 from the next cycle until return to IDLE.
REQ-014 RUN: sobel_start registered high from the first RUN cycle; remain until sobel_done sampled high.
REQ-015 On sobel_done high: sobel_start low next cycle, output counter = 0, -> DRAIN_RD.
REQ-016 DRAIN_RD: GX/GY_read_en=1 and both read addresses = output counter for exactly one cycle; -> DRAIN_WAIT.
REQ-017 DRAIN_WAIT: first cycle captures {GX,GY} read data into m_data and sets m_valid; m_data stable while m_valid&!m_ready.
REQ-018 m_last=1 with the word at counter NUMBER_OF_OUTPUT_WORDS-1 only.
REQ-019 On m_valid&m_ready: m_valid drops; if last word -> IDLE, else counter+1 -> DRAIN_RD. Peak rate one result per 2 cycles.
REQ-020 s_valid in RUN/DRAIN states is ignored (not accepted); no A_RAM writes outside LOAD/IDLE.
REQ-021 sobel_done high outside RUN is ignored.
REQ-022 Frames repeat indefinitely; address counters restart at 0 each frame.

Reset
REQ-023 On reset: state IDLE; s_ready=1 on the cycle after release; A_write_en, sobel_start, GX/GY_read_en, m_valid, m_last, err =0; all counters and m_data =0.
REQ-024 Reset mid-frame (any state) aborts immediately; partial A_RAM content is not cleared; sobel_start drops on the next edge.

Configuration
REQ-025 Macro FRAME_LAST_CHECK_EN defined: err set when s_last=1 on an accepted beat other than address NUMBER_OF_INPUT_WORDS-1, or s_last=0 on that beat; err clears only on reset; sequencing unaffected.
REQ-026 Macro undefined: s_last ignored, err tied 0.

Structure
REQ-027 Shared package sobel_pkg holds the state encoding, image_size=128, kernel_size=3, and word-count constants shared with the sobel engine.
REQ-028 One sub-module: sobel_drain_reader (DRAIN_RD/DRAIN_WAIT address, read strobe, output register, m_last); LOAD/RUN sequencing stays at top level.

Verification
REQ-029 Reset held 3 cycles, then 16384 beats s_data=addr[7:0], s_valid=1 -> A_write_address 0..16383 contiguous, sobel_start rises 1 cycle after beat 16383.
REQ-030 Stub engine raises sobel_done 50 cycles after start -> sobel_start low next cycle, first GX_read_en with address 0 the cycle after.
REQ-031 RAM model GX=addr[7:0], GY=~addr[7:0], m_ready=1 -> 15876 words, m_data[15:8]=addr[7:0], m_last only on word 15875, busy drops after it.
REQ-032 m_ready toggled pseudo-randomly -> m_data never changes while m_valid&!m_ready; no word lost or duplicated.
REQ-033 reset pulsed in RUN at cycle 20 -> sobel_start 0 next cycle, state IDLE, s_ready 1; next frame completes normally.
REQ-034 FRAME_LAST_CHECK_EN: s_last on beat 100 -> err=1 from next cycle, frame still completes all 15876 outputs.
